// File: rtl/bcd_seg_scan_pkg.sv
// Shared definitions for the multiplexed BCD seven-segment scanner:
// segment codes ({g,f,e,d,c,b,a}, 1 = lit), the dash code and FSM encoding.
package bcd_seg_scan_pkg;

  localparam int NUM_DIGITS = 5;

  typedef enum logic {
    S_ON  = 1'b0,
    S_GAP = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Five-digit multiplexed seven-segment scanner. Each digit slot lasts CLK_DIV
// cycles: an ON phase followed by GAP_CYCLES of blanking to avoid ghosting.
// New digits land in a shadow register and are moved to the display register
// only when digit 0 starts, so a frame never mixes two values.
// All outputs come straight from registers; the register inputs are computed
// from next-state values so the outputs line up with the state they describe.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       fin,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [4:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam logic [15:0] CNT_MAX     = 16'(CLK_DIV - 1);
  localparam logic [15:0] CNT_ON_LAST = 16'(CLK_DIV - GAP_CYCLES - 1);
  localparam logic [15:0] CNT_RST     = 16'(CLK_DIV - GAP_CYCLES);
  localparam logic [2:0]  LAST_DIGIT  = 3'(NUM_DIGITS - 1);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [4:0][3:0] shadow_q, shadow_d;
  logic [4:0][3:0] display_q, display_d;
  logic [6:0]      seg_q, seg_d;
  logic [4:0]      an_q, an_d;
  logic            frame_done_q, frame_done_d;

  logic [6:0]      dec_seg;
  logic            lz_blank;
  logic            zero_run;

  bcd_to_seg7 u_dec (
    .bcd_i (display_d[idx_d]),
    .seg_o (dec_seg)
  );

  // Next-state: slot counter, ON/GAP phase, digit index, shadow/display copy, outputs
  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? 16'd0 : cnt_q + 16'd1;
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;

    case (state_q)
      S_ON:    if (cnt_q == CNT_ON_LAST) state_d = S_GAP;
      S_GAP:   if (cnt_q == CNT_MAX)     state_d = S_ON;
      default: state_d = S_GAP;
    endcase

    if (state_q == S_GAP && state_d == S_ON) begin
      idx_d = (idx_q == LAST_DIGIT) ? 3'd0 : idx_q + 3'd1;
      // Frame boundary: latch the pre-edge shadow so the whole frame is consistent
      if (idx_d == 3'd0) display_d = shadow_q;
    end

    if (fin) shadow_d = {bcd4, bcd3, bcd2, bcd1, bcd0};

    // A digit is a leading zero when it and every more significant digit are 0
    zero_run = 1'b1;
    lz_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (display_d[k] == 4'd0);
      if (idx_d == 3'(k)) lz_blank = zero_run;
    end

    an_d         = 5'd0;
    seg_d        = SEG_BLANK;
    if (state_d == S_ON) begin
      an_d  = 5'b00001 << idx_d;
      seg_d = (blank_lz && lz_blank) ? SEG_BLANK : dec_seg;
    end
    frame_done_d = (state_d == S_GAP) && (cnt_d == CNT_MAX) && (idx_d == LAST_DIGIT);
  end

  // State and output registers; reset parks in the gap before digit 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_GAP;
      cnt_q        <= CNT_RST;
      idx_q        <= LAST_DIGIT;
      shadow_q     <= '0;
      display_q    <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 5'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign an         = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan (CLK_DIV=8, GAP_CYCLES=2, ACTIVE_LOW=0). A frame-position
// model predicts every output each cycle; directed literal checks pin the model.
module tb_bcd_seg_scan;

  localparam int CD = 8;
  localparam int GP = 2;
  localparam int FR = 5 * CD;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       fin = 1'b0;
  logic [3:0] b [5];
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [4:0] an;
  logic [2:0] digit_idx;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model state: position within a 40-cycle frame, shadow and displayed digits
  int         m_pos;
  logic [3:0] m_shadow [5];
  logic [3:0] m_disp [5];
  logic       m_blz;
  logic [6:0] DEC [16];

  bcd_seg_scan #(.CLK_DIV(CD), .GAP_CYCLES(GP), .ACTIVE_LOW(0)) dut (
    .CLK(CLK), .RST(RST), .fin(fin),
    .bcd0(b[0]), .bcd1(b[1]), .bcd2(b[2]), .bcd3(b[3]), .bcd4(b[4]),
    .blank_lz(blank_lz), .seg(seg), .an(an), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: position advances every cycle, frame starts copy shadow
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_pos <= CD - GP + 4 * CD;
      for (int j = 0; j < 5; j++) begin
        m_shadow[j] <= 4'd0;
        m_disp[j]   <= 4'd0;
      end
      m_blz <= 1'b0;
    end else begin
      m_pos <= (m_pos + 1) % FR;
      if ((m_pos + 1) % FR == 0)
        for (int j = 0; j < 5; j++) m_disp[j] <= m_shadow[j];
      if (fin)
        for (int j = 0; j < 5; j++) m_shadow[j] <= b[j];
      m_blz <= blank_lz;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_compare();
    int d, off;
    logic [4:0] ea;
    logic [6:0] es;
    bit z;
    d = m_pos / CD;
    off = m_pos % CD;
    ea = 5'd0;
    es = 7'h00;
    if (off < CD - GP) begin
      ea = 5'(1 << d);
      z = 1'b1;
      for (int j = d; j < 5; j++) if (m_disp[j] != 4'd0) z = 1'b0;
      es = (m_blz && d > 0 && z) ? 7'h00 : DEC[m_disp[d]];
    end
    chk("model_an", an, ea);
    chk("model_seg", seg, es);
    chk("model_digit_idx", digit_idx, d);
    chk("model_frame_done", frame_done, (m_pos == FR - 1) ? 1 : 0);
  endtask

  task automatic tick();
    @(negedge CLK);
    if (chk_en) model_compare();
  endtask

  task automatic wait_an(input logic [4:0] v, input string nm);
    int n;
    n = 0;
    do begin tick(); n++; end while (an !== v && n < 200);
    chk({nm, "_reach"}, an, v);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin tick(); n++; end while (frame_done !== 1'b1 && n < 100);
    chk("wait_frame_done", frame_done, 1);
  endtask

  task automatic pulse_fin(input logic [3:0] d4, d3, d2, d1, d0);
    fin = 1'b1;
    b[4] = d4; b[3] = d3; b[2] = d2; b[1] = d1; b[0] = d0;
    tick();
    fin = 1'b0;
  endtask

  initial begin
    int n;
    DEC = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    for (int j = 0; j < 5; j++) b[j] = 4'd0;

    // Reset state
    tick(); tick();
    chk("rst_an", an, 5'd0);
    chk("rst_seg", seg, 7'h00);
    chk("rst_digit_idx", digit_idx, 3'd4);
    chk("rst_frame_done", frame_done, 0);
    chk_en = 1'b1;
    tick();
    RST = 1'b1;

    // Start-up sequence after release
    tick(); chk("start_k1_an", an, 5'b00000);
    tick(); chk("start_k2_an", an, 5'b00001); chk("start_k2_seg", seg, 7'h3F);
    for (int i = 0; i < 5; i++) tick();
    chk("start_k7_an", an, 5'b00001);
    tick(); chk("start_k8_an", an, 5'b00000);
    tick(); chk("start_k9_an", an, 5'b00000);
    tick(); chk("start_k10_an", an, 5'b00010); chk("start_k10_seg", seg, 7'h3F);

    // Mid-frame update shows up only in the next frame
    pulse_fin(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    chk("midframe_unchanged", seg, 7'h3F);
    wait_an(5'b00001, "nf_d0"); chk("nf_d0_seg", seg, 7'h6D);
    wait_an(5'b00010, "nf_d1"); chk("nf_d1_seg", seg, 7'h66);
    wait_an(5'b00100, "nf_d2"); chk("nf_d2_seg", seg, 7'h4F);
    wait_an(5'b01000, "nf_d3"); chk("nf_d3_seg", seg, 7'h5B);
    wait_an(5'b10000, "nf_d4"); chk("nf_d4_seg", seg, 7'h06);

    // Update coinciding with the digit-0 entry edge
    wait_fd();
    pulse_fin(4'd8, 4'd6, 4'd0, 4'd7, 4'd9);
    chk("entry_d0_an", an, 5'b00001);
    chk("entry_d0_old", seg, 7'h6D);
    wait_an(5'b10000, "entry_d4"); chk("entry_d4_old", seg, 7'h06);
    wait_an(5'b00001, "next_d0"); chk("next_d0_new", seg, 7'h6F);
    wait_an(5'b10000, "next_d4"); chk("next_d4_new", seg, 7'h7F);

    // Leading-zero blanking on 00070
    blank_lz = 1'b1;
    pulse_fin(4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
    wait_fd();
    wait_an(5'b00001, "lz_d0"); chk("lz_d0_seg", seg, 7'h3F);
    wait_an(5'b00010, "lz_d1"); chk("lz_d1_seg", seg, 7'h07);
    wait_an(5'b00100, "lz_d2"); chk("lz_d2_seg", seg, 7'h00);
    wait_an(5'b01000, "lz_d3"); chk("lz_d3_seg", seg, 7'h00);
    wait_an(5'b10000, "lz_d4"); chk("lz_d4_seg", seg, 7'h00);
    blank_lz = 1'b0;
    wait_fd();
    wait_an(5'b00100, "nolz_d2"); chk("nolz_d2_seg", seg, 7'h3F);
    wait_an(5'b01000, "nolz_d3"); chk("nolz_d3_seg", seg, 7'h3F);
    wait_an(5'b10000, "nolz_d4"); chk("nolz_d4_seg", seg, 7'h3F);

    // Non-BCD code and frame_done period
    pulse_fin(4'd0, 4'd0, 4'hC, 4'd0, 4'd0);
    wait_fd();
    wait_an(5'b00100, "dash_d2"); chk("dash_d2_seg", seg, 7'h40);
    wait_fd();
    n = 0;
    do begin tick(); n++; end while (frame_done !== 1'b1 && n < 100);
    chk("frame_done_period", n, 40);
    tick(); chk("after_fd_an", an, 5'b00001); chk("after_fd_fd", frame_done, 0);

    // Asynchronous reset while digit 3 is lit
    wait_an(5'b01000, "arst_d3");
    #3 RST = 1'b0;
    #1;
    chk("arst_an", an, 5'd0);
    chk("arst_seg", seg, 7'h00);
    chk("arst_digit_idx", digit_idx, 3'd4);
    chk("arst_frame_done", frame_done, 0);
    tick(); tick();
    RST = 1'b1;
    tick(); chk("restart_k1_an", an, 5'b00000);
    tick(); chk("restart_k2_an", an, 5'b00001); chk("restart_k2_seg", seg, 7'h3F);
    wait_an(5'b00100, "restart_d2"); chk("restart_d2_seg", seg, 7'h3F);

    // Randomized traffic, including one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      fin = ($urandom % 6 == 0);
      if (fin)
        for (int j = 0; j < 5; j++)
          b[j] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
      if ($urandom % 50 == 0) blank_lz = ~blank_lz;
      if (i == 700) begin
        #3 RST = 1'b0;
        #1 chk("rand_arst_an", an, 5'd0);
        tick();
        RST = 1'b1;
      end
      tick();
    end
    fin = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
